// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    // Registered output bundle, updated together with the state register.
    typedef struct packed {
        logic busy;
        logic dout;
        logic dout_valid;
        logic pat_last;
        logic done;
    } tx_out_t;

    localparam tx_out_t OUT_IDLE = '0;
    localparam tx_out_t OUT_DONE = '{busy: 1'b1, dout: 1'b0, dout_valid: 1'b0,
                                     pat_last: 1'b0, done: 1'b1};

    // Outputs for a cycle that carries a stream bit (pattern or gap zero).
    function automatic tx_out_t out_stream(input logic d, input logic last);
        return '{busy: 1'b1, dout: d, dout_valid: 1'b1, pat_last: last, done: 1'b0};
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated
// a programmable number of times with idle-zero gaps between instances.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// SHIFT | emitting pattern bits from shreg
// GAP   | emitting zero gap bits between pattern instances
// DONE  | one-cycle completion pulse, then back to IDLE
//
// Outputs are registered: every transition also loads the output values
// that belong to the destination state, so they are glitch-free and clear
// immediately when reset asserts.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             busy,
    output logic             dout,
    output logic             dout_valid,
    output logic             pat_last,
    output logic             done
);

    localparam int BC_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BC_W-1:0] BIT_TOP = BC_W'(PAT_W - 1);

    tx_state_t        state;
    tx_out_t          outs;
    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] pat_q;
    logic [BC_W-1:0]  bit_cnt;
    logic [CNT_W-1:0] rep_rem;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;

    assign busy       = outs.busy;
    assign dout       = outs.dout;
    assign dout_valid = outs.dout_valid;
    assign pat_last   = outs.pat_last;
    assign done       = outs.done;

    // Sequencer: state, shift register, down-counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            outs    <= OUT_IDLE;
            shreg   <= '0;
            pat_q   <= '0;
            bit_cnt <= '0;
            rep_rem <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (repeat_cnt != '0)) begin
                        shreg   <= pattern;
                        pat_q   <= pattern;
                        rep_rem <= repeat_cnt;
                        gap_q   <= gap_len;
                        bit_cnt <= BIT_TOP;
                        state   <= SHIFT;
                        // PAT_W >= 2, so the first bit is never the last one.
                        outs    <= out_stream(pattern[PAT_W-1], 1'b0);
                    end else if (start) begin
                        state <= DONE;
                        outs  <= OUT_DONE;
                    end else begin
                        outs <= OUT_IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - BC_W'(1);
                        outs    <= out_stream(shreg[PAT_W-2], bit_cnt == BC_W'(1));
                    end else if (rep_rem <= CNT_W'(1)) begin
                        state <= DONE;
                        outs  <= OUT_DONE;
                    end else if (gap_q != '0) begin
                        rep_rem <= rep_rem - CNT_W'(1);
                        gap_cnt <= gap_q - GAP_W'(1);
                        state   <= GAP;
                        outs    <= out_stream(1'b0, 1'b0);
                    end else begin
                        rep_rem <= rep_rem - CNT_W'(1);
                        shreg   <= pat_q;
                        bit_cnt <= BIT_TOP;
                        outs    <= out_stream(pat_q[PAT_W-1], 1'b0);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                        outs    <= out_stream(1'b0, 1'b0);
                    end else begin
                        shreg   <= pat_q;
                        bit_cnt <= BIT_TOP;
                        state   <= SHIFT;
                        outs    <= out_stream(pat_q[PAT_W-1], 1'b0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    outs  <= OUT_IDLE;
                end
                default: begin
                    state <= IDLE;
                    outs  <= OUT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: streams with and without gaps,
// ignored restart, zero repeat count and mid-stream reset.
module tb_seq_pattern_tx;
    import seq_tx_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [2:0] gap_len;
    logic       busy, dout, dout_valid, pat_last, done;

    int passed = 0;
    int total  = 0;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pat_last   (pat_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_dout"}, dout, 1'b0);
        chk({tag, "_valid"}, dout_valid, 1'b0);
        chk({tag, "_last"}, pat_last, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // Drive a start request that the DUT samples on the next rising edge.
    task automatic do_start(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g);
        @(negedge clk);
        pattern    = p;
        repeat_cnt = r;
        gap_len    = g;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One stream cycle, sampled on the falling edge.
    task automatic chk_bit(input string tag, input logic b, input logic last);
        @(negedge clk);
        chk({tag, "_valid"}, dout_valid, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_dout"}, dout, b);
        chk({tag, "_last"}, pat_last, last);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // DONE cycle followed by a return to IDLE.
    task automatic chk_tail(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_done_busy"}, busy, 1'b1);
        chk({tag, "_done_valid"}, dout_valid, 1'b0);
        chk({tag, "_done_dout"}, dout, 1'b0);
        @(negedge clk);
        chk_idle({tag, "_after"});
    endtask

    // Check n stream cycles (MSB of the vectors first), then DONE and IDLE.
    task automatic expect_stream(input string tag, input logic [31:0] bits,
                                 input logic [31:0] last, input int n);
        for (int i = 0; i < n; i++)
            chk_bit(tag, bits[n-1-i], last[n-1-i]);
        chk_tail(tag);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap_len    = '0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        // 1: single instance, no gap
        do_start(DEFAULT_PATTERN, 4'd1, 3'd0);
        expect_stream("t1", 32'b1010, 32'b0001, 4);

        // 2: three instances with two gap bits
        do_start(DEFAULT_PATTERN, 4'd3, 3'd2);
        expect_stream("t2", 32'b1010_0010_1000_1010, 32'b0001_0000_0100_0001, 16);

        // 3: back-to-back instances
        do_start(DEFAULT_PATTERN, 4'd2, 3'd0);
        expect_stream("t3", 32'b1010_1010, 32'b0001_0001, 8);

        // 4: second start and new pattern while busy are ignored
        do_start(4'b1100, 4'd2, 3'd0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_bits;
            logic [7:0] exp_last;
            exp_bits = 8'b1100_1100;
            exp_last = 8'b0001_0001;
            chk_bit("t4", exp_bits[7-i], exp_last[7-i]);
            if (i == 2) begin
                pattern    = 4'b0011;
                repeat_cnt = 4'd5;
                start      = 1'b1;
            end else if (i == 3) begin
                start = 1'b0;
            end
        end
        chk_tail("t4");

        // 5: zero repeat count goes straight to DONE
        do_start(DEFAULT_PATTERN, 4'd0, 3'd1);
        chk_tail("t5");

        // 6: reset during the second bit, then a clean run
        do_start(4'b1100, 4'd1, 3'd0);
        chk_bit("t6_pre", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_bit2_dout", dout, 1'b1);
        chk("t6_bit2_valid", dout_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk_idle("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("t6_idle");
        do_start(DEFAULT_PATTERN, 4'd1, 3'd0);
        expect_stream("t6", 32'b1010, 32'b0001, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
